// File: rtl/l2_tag_ways.sv
// Set-associative L2 tag store: one-cycle registered lookup (hit + victim), fill, mark_dirty and an invalidate sweep.
// No backpressure: requests arriving while busy are dropped. `define L2_TAG_PLRU_EN selects tree PLRU over round-robin.
module l2_tag_ways #(
  parameter  int TAG_W = 24,
  parameter  int IDX_W = 3,
  parameter  int WAYS  = 4,
  localparam int SETS  = 2**IDX_W,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             fill,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             fill_dirty,
  input  logic             mark_dirty,
  input  logic [IDX_W-1:0] md_idx,
  input  logic [WAY_W-1:0] md_way,
  input  logic             flush,
  output logic             busy,
  output logic             rsp_valid,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  output logic [TAG_W-1:0] victim_tag,
  output logic             victim_dirty
);

`ifdef L2_TAG_PLRU_EN
  localparam int RS_W = WAYS - 1;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [RS_W-1:0] plru_touch(input logic [RS_W-1:0] s, input logic [WAY_W-1:0] w);
    logic [RS_W-1:0] r;
    int              node;
    r    = s;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~w[WAY_W-1-l];
      node    = 2*node + 1 + int'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [RS_W-1:0] s);
    logic [WAY_W-1:0] v;
    int               node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = s[node];
      node         = 2*node + 1 + int'(s[node]);
    end
    return v;
  endfunction
`else
  localparam int RS_W = WAY_W;
`endif

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_d   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-1:0]  dirty_d [SETS];
  logic [RS_W-1:0]  repl_q  [SETS];
  logic [RS_W-1:0]  repl_d  [SETS];

  logic             rsp_valid_q, rsp_valid_d;
  logic             hit_q, hit_d;
  logic [WAY_W-1:0] hit_way_q, hit_way_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic [TAG_W-1:0] victim_tag_q, victim_tag_d;
  logic             victim_dirty_q, victim_dirty_d;

  logic             l_hit, l_any_inv;
  logic [WAY_W-1:0] l_way, l_victim;

  // Descending scan so the lowest-numbered match / invalid way wins.
  always_comb begin
    l_hit     = 1'b0;
    l_way     = '0;
    l_any_inv = 1'b0;
    l_victim  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag_in)) begin
        l_hit = 1'b1;
        l_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        l_any_inv = 1'b1;
        l_victim  = WAY_W'(w);
      end
    end
    if (!l_any_inv) begin
`ifdef L2_TAG_PLRU_EN
      l_victim = plru_victim(repl_q[idx]);
`else
      l_victim = repl_q[idx];
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_idx_d    = sweep_idx_q;
    tag_d          = tag_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    repl_d         = repl_q;
    rsp_valid_d    = 1'b0;
    hit_d          = hit_q;
    hit_way_d      = hit_way_q;
    victim_way_d   = victim_way_q;
    victim_tag_d   = victim_tag_q;
    victim_dirty_d = victim_dirty_q;

    if (state_q == SWEEP) begin
      valid_d[sweep_idx_q] = '0;
      dirty_d[sweep_idx_q] = '0;
      repl_d[sweep_idx_q]  = '0;
      sweep_idx_d          = sweep_idx_q + IDX_W'(1);
      if (sweep_idx_q == IDX_W'(SETS-1)) state_d = IDLE;
    end else begin
      if (flush) begin
        state_d     = SWEEP;
        sweep_idx_d = '0;
      end
      if (lookup) begin
        rsp_valid_d    = 1'b1;
        hit_d          = l_hit;
        hit_way_d      = l_way;
        victim_way_d   = l_victim;
        victim_tag_d   = tag_q[idx][l_victim];
        victim_dirty_d = dirty_q[idx][l_victim] & valid_q[idx][l_victim];
`ifdef L2_TAG_PLRU_EN
        if (l_hit) repl_d[idx] = plru_touch(repl_q[idx], l_way);
`endif
      end
      if (mark_dirty && valid_q[md_idx][md_way]) dirty_d[md_idx][md_way] = 1'b1;
      // Fill is applied last so it overrides a same-line mark_dirty.
      if (fill) begin
        tag_d[fill_idx][fill_way]   = fill_tag;
        valid_d[fill_idx][fill_way] = 1'b1;
        dirty_d[fill_idx][fill_way] = fill_dirty;
`ifdef L2_TAG_PLRU_EN
        repl_d[fill_idx] = plru_touch(repl_d[fill_idx], fill_way);
`else
        repl_d[fill_idx] = repl_d[fill_idx] + RS_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sweep_idx_q    <= '0;
      rsp_valid_q    <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      victim_way_q   <= '0;
      victim_tag_q   <= '0;
      victim_dirty_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        repl_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sweep_idx_q    <= sweep_idx_d;
      rsp_valid_q    <= rsp_valid_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      victim_way_q   <= victim_way_d;
      victim_tag_q   <= victim_tag_d;
      victim_dirty_q <= victim_dirty_d;
      tag_q          <= tag_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      repl_q         <= repl_d;
    end
  end

  assign busy         = (state_q == SWEEP);
  assign rsp_valid    = rsp_valid_q;
  assign hit          = hit_q;
  assign hit_way      = hit_way_q;
  assign victim_way   = victim_way_q;
  assign victim_tag   = victim_tag_q;
  assign victim_dirty = victim_dirty_q;

endmodule

// File: tb/tb_l2_tag_ways.sv
// Bench for l2_tag_ways (WAYS=4, IDX_W=3, TAG_W=24): directed vector table, flush/reset sequences,
// then random traffic against a set/way reference model.
module tb_l2_tag_ways;

`ifdef L2_TAG_PLRU_EN
  localparam bit PLRU = 1'b1;
`else
  localparam bit PLRU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, lookup, fill, fill_dirty, mark_dirty, flush;
  logic [2:0]  idx, fill_idx, md_idx;
  logic [1:0]  fill_way, md_way;
  logic [23:0] tag_in, fill_tag;
  logic        busy, rsp_valid, hit, victim_dirty;
  logic [1:0]  hit_way, victim_way;
  logic [23:0] victim_tag;

  l2_tag_ways #(.TAG_W(24), .IDX_W(3), .WAYS(4)) dut (
    .clk(clk), .reset(reset), .lookup(lookup), .idx(idx), .tag_in(tag_in),
    .fill(fill), .fill_idx(fill_idx), .fill_way(fill_way), .fill_tag(fill_tag), .fill_dirty(fill_dirty),
    .mark_dirty(mark_dirty), .md_idx(md_idx), .md_way(md_way), .flush(flush),
    .busy(busy), .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_tag(victim_tag), .victim_dirty(victim_dirty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain per-set/way arrays.
  logic [23:0] m_tag [8][4];
  bit          m_val [8][4];
  bit          m_dty [8][4];
  int          m_rr  [8];
  bit          m_pl  [8][3];
  int          m_sweep = -1;
  bit          e_busy, e_rsp, e_hit, e_vd;
  int          e_hw, e_vw;
  logic [23:0] e_vt;

  // Tree walk by range halving; node bit 0 means "victim in lower half".
  function automatic void pl_touch(int s, int w);
    int node = 0;
    int lo = 0;
    int sz = 4;
    while (sz > 1) begin
      sz = sz / 2;
      if (w < lo + sz) begin
        m_pl[s][node] = 1'b1;
        node = 2*node + 1;
      end else begin
        m_pl[s][node] = 1'b0;
        lo = lo + sz;
        node = 2*node + 2;
      end
    end
  endfunction

  function automatic int pl_victim(int s);
    int node = 0;
    int lo = 0;
    int sz = 4;
    while (sz > 1) begin
      sz = sz / 2;
      if (!m_pl[s][node]) node = 2*node + 1;
      else begin
        lo = lo + sz;
        node = 2*node + 2;
      end
    end
    return lo;
  endfunction

  task automatic model_step();
    bit h;
    int hw, vw, s;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_rr[i] = 0;
        for (int w = 0; w < 4; w++) begin
          m_tag[i][w] = '0; m_val[i][w] = 0; m_dty[i][w] = 0;
        end
        for (int n = 0; n < 3; n++) m_pl[i][n] = 0;
      end
      m_sweep = -1;
      e_rsp = 0; e_hit = 0; e_hw = 0; e_vw = 0; e_vt = '0; e_vd = 0;
    end else if (m_sweep >= 0) begin
      s = m_sweep;
      for (int w = 0; w < 4; w++) begin m_val[s][w] = 0; m_dty[s][w] = 0; end
      for (int n = 0; n < 3; n++) m_pl[s][n] = 0;
      m_rr[s] = 0;
      m_sweep = (s == 7) ? -1 : s + 1;
      e_rsp = 0;
    end else begin
      e_rsp = 0;
      if (lookup) begin
        h = 0; hw = 0; vw = -1;
        for (int w = 0; w < 4; w++) begin
          if (!h && m_val[idx][w] && m_tag[idx][w] == tag_in) begin h = 1; hw = w; end
          if (vw < 0 && !m_val[idx][w]) vw = w;
        end
        if (vw < 0) vw = PLRU ? pl_victim(int'(idx)) : m_rr[idx];
        e_rsp = 1; e_hit = h; e_vw = vw;
        if (h) e_hw = hw;
        e_vt = m_tag[idx][vw];
        e_vd = m_val[idx][vw] && m_dty[idx][vw];
        if (h && PLRU) pl_touch(int'(idx), hw);
      end
      if (mark_dirty && m_val[md_idx][md_way]) m_dty[md_idx][md_way] = 1;
      if (fill) begin
        m_tag[fill_idx][fill_way] = fill_tag;
        m_val[fill_idx][fill_way] = 1;
        m_dty[fill_idx][fill_way] = fill_dirty;
        if (PLRU) pl_touch(int'(fill_idx), int'(fill_way));
        else m_rr[fill_idx] = (m_rr[fill_idx] + 1) % 4;
      end
      if (flush) m_sweep = 0;
    end
    e_busy = (m_sweep >= 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_busy", busy, e_busy);
    chk("m_rsp_valid", rsp_valid, e_rsp);
    chk("m_hit", hit, e_hit);
    if (e_hit) chk("m_hit_way", hit_way, e_hw);
    chk("m_victim_way", victim_way, e_vw);
    chk("m_victim_tag", victim_tag, e_vt);
    chk("m_victim_dirty", victim_dirty, e_vd);
  endtask

  task automatic idle_inputs();
    lookup = 0; idx = '0; tag_in = '0;
    fill = 0; fill_idx = '0; fill_way = '0; fill_tag = '0; fill_dirty = 0;
    mark_dirty = 0; md_idx = '0; md_way = '0; flush = 0;
  endtask

  typedef struct {
    logic        lk;  logic [2:0] li;  logic [23:0] lt;
    logic        fl;  logic [2:0] fi;  logic [1:0]  fw;  logic [23:0] ft;  logic fd;
    logic        md;  logic [2:0] mi;  logic [1:0]  mw;
    logic        e_rsp; logic e_hit; logic [1:0] e_hw; logic [1:0] e_vw; logic [23:0] e_vt; logic e_vd;
  } vec_t;

  function automatic vec_t v_lk(int i, int t, bit h, int hw, int vw, int vt, bit vd);
    vec_t v = '{default: 0};
    v.lk = 1; v.li = 3'(i); v.lt = 24'(t);
    v.e_rsp = 1; v.e_hit = h; v.e_hw = 2'(hw); v.e_vw = 2'(vw); v.e_vt = 24'(vt); v.e_vd = vd;
    return v;
  endfunction

  function automatic vec_t v_fl(int i, int w, int t, bit d);
    vec_t v = '{default: 0};
    v.fl = 1; v.fi = 3'(i); v.fw = 2'(w); v.ft = 24'(t); v.fd = d;
    return v;
  endfunction

  function automatic vec_t v_md(int i, int w);
    vec_t v = '{default: 0};
    v.md = 1; v.mi = 3'(i); v.mw = 2'(w);
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = v_lk(2, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v_fl(5, 2, 24'hABCDEF, 0);
    tbl[2]  = v_lk(5, 24'hABCDEF, 1, 2, 0, 0, 0);
    for (int w = 0; w < 4; w++) tbl[3+w] = v_fl(1, w, 24'h10 + w, 0);
    tbl[7]  = v_lk(1, 24'h10, 1, 0, 0, 24'h10, 0);
    tbl[8]  = v_lk(1, 24'h99, 0, 0, PLRU ? 2 : 0, PLRU ? 24'h12 : 24'h10, 0);
    tbl[9]  = v_md(1, 2);
    tbl[10] = v_lk(1, 24'h99, 0, 0, PLRU ? 2 : 0, PLRU ? 24'h12 : 24'h10, PLRU);
    tbl[11] = v_fl(6, 1, 24'h61, 0);
    tbl[12] = v_fl(6, 2, 24'h62, 0);
    tbl[13] = v_fl(6, 3, 24'h63, 0);
    tbl[14] = v_lk(6, 24'h60, 0, 0, 0, 0, 0);
    tbl[14].fl = 1; tbl[14].fi = 3'd6; tbl[14].fw = 2'd0; tbl[14].ft = 24'h60; tbl[14].fd = 1;
    tbl[15] = v_lk(6, 24'h60, 1, 0, PLRU ? 2 : 0, PLRU ? 24'h62 : 24'h60, !PLRU);
    tbl[16] = v_fl(6, 3, 24'h61, 0);
    tbl[17] = v_lk(6, 24'h61, 1, 1, 1, 24'h61, 0);

    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_way", hit_way, 0);
    chk("rst_victim_way", victim_way, 0);
    chk("rst_victim_tag", victim_tag, 0);
    chk("rst_victim_dirty", victim_dirty, 0);

    foreach (tbl[i]) begin
      lookup = tbl[i].lk; idx = tbl[i].li; tag_in = tbl[i].lt;
      fill = tbl[i].fl; fill_idx = tbl[i].fi; fill_way = tbl[i].fw; fill_tag = tbl[i].ft; fill_dirty = tbl[i].fd;
      mark_dirty = tbl[i].md; md_idx = tbl[i].mi; md_way = tbl[i].mw;
      tick();
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_rsp);
      if (tbl[i].e_rsp) begin
        chk($sformatf("tbl%0d_hit", i), hit, tbl[i].e_hit);
        if (tbl[i].e_hit) chk($sformatf("tbl%0d_hit_way", i), hit_way, tbl[i].e_hw);
        chk($sformatf("tbl%0d_victim_way", i), victim_way, tbl[i].e_vw);
        chk($sformatf("tbl%0d_victim_tag", i), victim_tag, tbl[i].e_vt);
        chk($sformatf("tbl%0d_victim_dirty", i), victim_dirty, tbl[i].e_vd);
      end
    end
    idle_inputs();

    // Flush: count busy cycles, poke ignored requests mid-sweep.
    flush = 1;
    tick();
    flush = 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      idx = 3'd5; tag_in = 24'hABCDEF;
      fill_idx = 3'd5; fill_way = 2'd1; fill_tag = 24'hABCDEF;
      lookup = (n == 2); flush = (n == 3); fill = (n == 4);
      tick();
      if (n == 2) chk("busy_lookup_rsp_valid", rsp_valid, 0);
      n++;
    end
    idle_inputs();
    chk("busy_cycles", n, 8);
    tick();
    tick();
    chk("flush_not_queued", busy, 0);
    lookup = 1; idx = 3'd5; tag_in = 24'hABCDEF;
    tick();
    idle_inputs();
    chk("post_flush_rsp_valid", rsp_valid, 1);
    chk("post_flush_hit", hit, 0);

    // Reset during the third sweep cycle abandons the sweep.
    flush = 1;
    tick();
    flush = 0;
    tick();
    tick();
    chk("sweep3_busy", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("midsweep_rst_busy", busy, 0);
    lookup = 1; idx = 3'd5; tag_in = 24'hABCDEF;
    tick();
    idle_inputs();
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_hit", hit, 0);

    // Random traffic concentrated on a couple of sets to force collisions.
    for (int c = 0; c < 1500; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      lookup     = ($urandom_range(0, 1) == 0);
      idx        = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      tag_in     = 24'($urandom_range(0, 5));
      fill       = ($urandom_range(0, 2) == 0);
      fill_idx   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      fill_way   = 2'($urandom_range(0, 3));
      fill_tag   = 24'($urandom_range(0, 5));
      fill_dirty = 1'($urandom_range(0, 1));
      mark_dirty = ($urandom_range(0, 3) == 0);
      md_idx     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      md_way     = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
